// File: rtl/buzzer_lock_controller_if.sv
// Player-code and quizmaster controls into the buzzer lock stage, with round status back out.
// The master drives the encoder code and the controls; the slave is the lock controller.
interface buzzer_lock_controller_if;
  logic [3:0] binary_out;
  logic       arm;
  logic       clear;
  logic [2:0] winner;
  logic       winner_valid;
  logic       armed;
  logic       buzz;
  logic       time_up;
  logic [3:0] penalty;

  modport master (
    output binary_out, arm, clear,
    input  winner, winner_valid, armed, buzz, time_up, penalty
  );

  modport slave (
    input  binary_out, arm, clear,
    output winner, winner_valid, armed, buzz, time_up, penalty
  );
endinterface

// File: rtl/buzzer_lock_controller.sv
// First-press lock for the buzzer system: qualifies a stable player code, latches the winner, times buzz/answer.
// Optional FALSE_START_EN: presses seen in IDLE set per-player penalty flags that mask that player for the round.
//
// state   | meaning
// IDLE    | waiting for arm; false starts recorded here
// ARMED   | round open, no candidate yet
// QUAL    | candidate code seen, counting consecutive stable cycles
// LOCKED  | winner latched, answer window running
// EXPIRED | answer window over, holding winner until clear
module buzzer_lock_controller #(
  parameter int QUAL_CYCLES = 4,
  parameter int BUZZ_CYCLES = 8,
  parameter int ANS_CYCLES  = 1000
) (
  input logic                      clk,
  input logic                      rst_n,
  buzzer_lock_controller_if.slave  bus
);
  localparam int QW = $clog2(QUAL_CYCLES + 1);
  localparam int BW = $clog2(BUZZ_CYCLES + 1);
  localparam int AW = $clog2(ANS_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, ARMED, QUAL, LOCKED, EXPIRED} state_t;

  state_t          state_q, state_d;
  logic [2:0]      cand_q, cand_d;
  logic [QW-1:0]   qual_q, qual_d;
  logic [BW-1:0]   buzz_cnt_q, buzz_cnt_d;
  logic [AW-1:0]   ans_cnt_q, ans_cnt_d;
  logic [2:0]      winner_q, winner_d;
  logic            winner_valid_q, armed_q, buzz_q, time_up_q;
  logic [3:0]      pen_q;
  logic [3:0]      code;
  logic            code_valid;
  logic            code_live;

  assign code       = ~bus.binary_out;
  assign code_valid = (code >= 4'd1) && (code <= 4'd4);

`ifdef FALSE_START_EN
  logic [1:0] pidx;
  // codes 1..4 map to penalty bits 0..3; code 4 wraps 2'b00-1 to 3
  assign pidx      = code[1:0] - 2'd1;
  assign code_live = code_valid && !pen_q[pidx];

  always_ff @(posedge clk) begin
    if (!rst_n || bus.clear)
      pen_q <= 4'b0000;
    else if (state_q == IDLE && code_valid)
      pen_q[pidx] <= 1'b1;
  end
`else
  assign code_live = code_valid;
  assign pen_q     = 4'b0000;
`endif

  always_comb begin
    state_d    = state_q;
    cand_d     = cand_q;
    qual_d     = qual_q;
    winner_d   = winner_q;
    ans_cnt_d  = ans_cnt_q;
    buzz_cnt_d = (buzz_cnt_q != '0) ? buzz_cnt_q - BW'(1) : '0;

    case (state_q)
      IDLE: begin
        if (bus.arm) state_d = ARMED;
      end
      ARMED: begin
        if (code_live) begin
          cand_d  = code[2:0];
          qual_d  = QW'(1);
          state_d = QUAL;
        end
      end
      QUAL: begin
        if (code_live && code == {1'b0, cand_q}) begin
          if (qual_q == QW'(QUAL_CYCLES - 1)) begin
            state_d    = LOCKED;
            winner_d   = cand_q;
            qual_d     = '0;
            buzz_cnt_d = BW'(BUZZ_CYCLES);
            ans_cnt_d  = AW'(ANS_CYCLES);
          end else begin
            qual_d = qual_q + QW'(1);
          end
        end else begin
          state_d = ARMED;
          qual_d  = '0;
        end
      end
      LOCKED: begin
        // remaining-cycle down-counter; expiry on the edge that would take it to zero
        if (ans_cnt_q <= AW'(1)) begin
          state_d   = EXPIRED;
          ans_cnt_d = '0;
        end else begin
          ans_cnt_d = ans_cnt_q - AW'(1);
        end
      end
      EXPIRED: ;
      default: state_d = IDLE;
    endcase

    if (bus.clear) begin
      state_d    = IDLE;
      cand_d     = '0;
      qual_d     = '0;
      winner_d   = '0;
      buzz_cnt_d = '0;
      ans_cnt_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cand_q         <= '0;
      qual_q         <= '0;
      buzz_cnt_q     <= '0;
      ans_cnt_q      <= '0;
      winner_q       <= '0;
      winner_valid_q <= 1'b0;
      armed_q        <= 1'b0;
      buzz_q         <= 1'b0;
      time_up_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cand_q         <= cand_d;
      qual_q         <= qual_d;
      buzz_cnt_q     <= buzz_cnt_d;
      ans_cnt_q      <= ans_cnt_d;
      winner_q       <= winner_d;
      winner_valid_q <= (state_d == LOCKED) || (state_d == EXPIRED);
      armed_q        <= (state_d == ARMED) || (state_d == QUAL);
      buzz_q         <= (buzz_cnt_d != '0);
      time_up_q      <= (state_d == EXPIRED);
    end
  end

  assign bus.winner       = winner_q;
  assign bus.winner_valid = winner_valid_q;
  assign bus.armed        = armed_q;
  assign bus.buzz         = buzz_q;
  assign bus.time_up      = time_up_q;
  assign bus.penalty      = pen_q;
endmodule

// File: tb/tb_buzzer_lock_controller.sv
// Directed bench for buzzer_lock_controller at default parameters (QUAL 4, BUZZ 8, ANS 1000).
// Expectations follow the FALSE_START_EN build setting.
module tb_buzzer_lock_controller;
`ifdef FALSE_START_EN
  localparam bit FS = 1'b1;
`else
  localparam bit FS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  buzzer_lock_controller_if bus ();

  buzzer_lock_controller dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".winner"},       32'(bus.winner),       32'd0);
    chk({tag, ".winner_valid"}, 32'(bus.winner_valid), 32'd0);
    chk({tag, ".armed"},        32'(bus.armed),        32'd0);
    chk({tag, ".buzz"},         32'(bus.buzz),         32'd0);
    chk({tag, ".time_up"},      32'(bus.time_up),      32'd0);
  endtask

  initial begin
    bus.binary_out = 4'b1111;
    bus.arm        = 1'b0;
    bus.clear      = 1'b0;
    rst_n          = 1'b0;
    tick();
    tick();
    chk_quiet("reset");
    chk("reset.penalty", 32'(bus.penalty), 32'd0);
    rst_n = 1'b1;

    // player 2 lock, buzz length, answer timeout
    bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
    chk("s1.armed", 32'(bus.armed), 32'd1);
    bus.binary_out = 4'b1101;
    repeat (3) tick();
    chk("s1.prelock_valid", 32'(bus.winner_valid), 32'd0);
    tick();
    chk("s1.winner",       32'(bus.winner),       32'd2);
    chk("s1.winner_valid", 32'(bus.winner_valid), 32'd1);
    chk("s1.buzz_rise",    32'(bus.buzz),         32'd1);
    chk("s1.armed_off",    32'(bus.armed),        32'd0);
    bus.binary_out = 4'b1111;
    repeat (7) tick();
    chk("s1.buzz_last", 32'(bus.buzz), 32'd1);
    tick();
    chk("s1.buzz_fall", 32'(bus.buzz), 32'd0);
    repeat (991) tick();
    chk("s1.time_up_early", 32'(bus.time_up), 32'd0);
    tick();
    chk("s1.time_up",      32'(bus.time_up),      32'd1);
    chk("s1.hold_winner",  32'(bus.winner),       32'd2);
    chk("s1.hold_valid",   32'(bus.winner_valid), 32'd1);
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    chk_quiet("s1.clear");

    // non-player codes, glitch on player 1, then player 4
    bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
    bus.binary_out = 4'b1010;
    repeat (5) tick();
    bus.binary_out = 4'b0000;
    repeat (5) tick();
    chk("s2.nopress_armed", 32'(bus.armed),        32'd1);
    chk("s2.nopress_valid", 32'(bus.winner_valid), 32'd0);
    bus.binary_out = 4'b1110;
    repeat (2) tick();
    bus.binary_out = 4'b1111;
    tick();
    bus.binary_out = 4'b1011;
    repeat (3) tick();
    chk("s2.no_lock_p1", 32'(bus.winner_valid), 32'd0);
    tick();
    chk("s2.winner", 32'(bus.winner),       32'd4);
    chk("s2.valid",  32'(bus.winner_valid), 32'd1);
    bus.binary_out = 4'b1111;
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    chk_quiet("s2.clear");

    // lockout of later presses
    bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
    bus.binary_out = 4'b1100;
    repeat (4) tick();
    chk("s3.winner", 32'(bus.winner), 32'd3);
    bus.binary_out = 4'b1110;
    repeat (50) tick();
    chk("s3.locked_winner", 32'(bus.winner),       32'd3);
    chk("s3.locked_valid",  32'(bus.winner_valid), 32'd1);
    bus.binary_out = 4'b1111;
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    chk_quiet("s3.clear");

    // clear beats arm; reset mid-qualification
    bus.arm   = 1'b1;
    bus.clear = 1'b1;
    tick();
    bus.arm   = 1'b0;
    bus.clear = 1'b0;
    chk("s4.clear_wins", 32'(bus.armed), 32'd0);
    tick();
    chk("s4.stay_idle", 32'(bus.armed), 32'd0);
    bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
    bus.binary_out = 4'b1101;
    repeat (2) tick();
    rst_n = 1'b0;
    bus.binary_out = 4'b1111;
    tick();
    chk_quiet("s4.reset_mid");
    rst_n = 1'b1;
    repeat (4) tick();
    chk("s4.no_lock", 32'(bus.winner_valid), 32'd0);
    chk("s4.idle",    32'(bus.armed),        32'd0);

    // false start by player 1 in IDLE
    bus.binary_out = 4'b1110;
    tick();
    chk("s5.penalty_idle", 32'(bus.penalty), FS ? 32'd1 : 32'd0);
    bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
    chk("s5.armed", 32'(bus.armed), 32'd1);
    repeat (4) tick();
    chk("s5.p1_valid",  32'(bus.winner_valid), FS ? 32'd0 : 32'd1);
    chk("s5.p1_winner", 32'(bus.winner),       FS ? 32'd0 : 32'd1);
    bus.binary_out = 4'b1101;
    repeat (4) tick();
    chk("s5.final_winner", 32'(bus.winner),       FS ? 32'd2 : 32'd1);
    chk("s5.final_valid",  32'(bus.winner_valid), 32'd1);
    chk("s5.penalty_held", 32'(bus.penalty),      FS ? 32'd1 : 32'd0);
    bus.binary_out = 4'b1111;
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    chk("s5.penalty_clear", 32'(bus.penalty), 32'd0);
    chk_quiet("s5.clear");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/buzzer_lock_controller.md
# buzzer_lock_controller

Sequential stage directly downstream of the 4-player priority encoder in the fastest-finger-first buzzer system. Consumes the encoder's active-low player code and qualifies a stable press while the round is armed. Latches the first qualified player as the winner and locks out everyone else until the quizmaster clears. Also drives a fixed-length buzzer pulse and an answer-window timeout.

## Interface
- QUAL_CYCLES, 4, consecutive cycles a code must be stable to qualify (legal range ≥2)
- BUZZ_CYCLES, 8, buzzer pulse length in cycles (≥1)
- ANS_CYCLES, 1000, answer window in cycles after lock (≥1)

- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  synchronous, active-low reset
- binary_out  input  4  active-low code from the priority encoder; 4'b1111 = no press
- arm  input  1  quizmaster start-round pulse, level-sampled
- clear  input  1  quizmaster clear, level-sampled
- winner  output  3  latched player number 1..4, 0 when none
- winner_valid  output  1  high while a winner is latched
- armed  output  1  high while waiting for or qualifying a press
- buzz  output  1  buzzer drive
- time_up  output  1  answer window expired
- penalty  output  4  per-player false-start flags, bit n-1 = player n

## Operation
- Decode: code = ~binary_out. Values 1..4 are players. 0 and 5..15 are treated as "no press".
- States: IDLE, ARMED, QUAL, LOCKED, EXPIRED.
- IDLE: arm=1 → ARMED. Outputs armed=0, winner_valid=0.
- ARMED, valid unpenalized code: candidate is set to the code, qual count is set to 1, and the FSM goes to QUAL.
- QUAL:
  - Code equal to candidate:
    - If count == QUAL_CYCLES-1 → LOCKED.
    - Otherwise the count increments.
  - Any other code, including no press → ARMED, count cleared.
- On entry to LOCKED:
  - winner = candidate, winner_valid = 1.
  - Buzz counter and answer counter load.
  - Later presses are ignored.
- LOCKED: answer counter reaches ANS_CYCLES → EXPIRED, time_up = 1.
- EXPIRED: holds winner, winner_valid and time_up.
- clear=1 in any state:
  - Next state is IDLE.
  - winner=0, winner_valid=0, buzz=0, time_up=0.
  - All counters are zeroed.
- clear has priority over arm and over qualification in the same cycle.
- arm outside IDLE is ignored.
- armed = 1 exactly in ARMED and QUAL.

## Timing
- All outputs are registered.
- Reset values (rst_n=0 at an edge): state IDLE, winner=0, winner_valid=0, armed=0, buzz=0, time_up=0, penalty=0, all counters 0.
- Reset mid-round aborts the round with no residue.
- arm high at edge k → armed high after edge k.
- Lock latency: a valid code sampled on QUAL_CYCLES consecutive edges while armed causes winner_valid to rise after the last of those edges. The first edge of the run is the one in ARMED.
- buzz:
  - Rises together with winner_valid.
  - Stays high exactly BUZZ_CYCLES cycles, including into EXPIRED if BUZZ_CYCLES > ANS_CYCLES.
  - Cut short by clear.
- time_up rises exactly ANS_CYCLES cycles after winner_valid rises and holds until clear.
- Glitch or switch: a code change during QUAL returns the FSM to ARMED. A new run starts on the next edge showing a valid code.
- Simultaneous presses are already resolved upstream by the encoder (player 4 highest). This block sees only one code.
- Counter widths are sized to their parameter. They never wrap: each saturates at its terminal value.

## Configuration
- FALSE_START_EN defined:
  - In IDLE, any decoded valid code n sets penalty[n-1].
  - penalty is frozen from ARMED through EXPIRED and cleared only by clear or reset.
  - In ARMED/QUAL a penalized player's code is treated as no press.
  - Because the encoder has priority, a penalized higher player who is holding masks lower players. This is accepted behaviour.
- FALSE_START_EN undefined: penalty is tied to 4'b0000 and no codes are masked.

## Test plan
- Reset, arm, then binary_out=4'b1101 held 4 cycles → after the 4th edge: winner=2, winner_valid=1, buzz high 8 cycles, time_up high 1000 cycles after lock.
- Armed, 4'b1110 for 2 cycles then 4'b1111, then 4'b1011 for 4 cycles → winner=4. No lock on player 1.
- After lock on player 3 (4'b1100), 4'b1110 held for 50 cycles → winner stays 3. clear → all outputs 0 next cycle, state IDLE.
- arm and clear high in the same IDLE cycle → stays IDLE, armed=0. rst_n=0 during QUAL → all outputs 0, no lock.
- FALSE_START_EN: 4'b1110 pressed in IDLE → penalty=4'b0001. Then arm with player 1 holding 4 cycles → no lock. Then 4'b1101 for 4 cycles → winner=2.
- No FALSE_START_EN, same stimulus as the previous scenario → penalty stays 0 and player 1 wins after 4 cycles.
